regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two writers: the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO. The pipeline writeback normally has priority.
- A starvation guard stalls the pipeline for one cycle so a waiting MDU result can drain.
- A busy-bit scoreboard reports read hazards on registers with an outstanding MDU result.
- Sits between the WB/MDU stages and the register file's RegWrite/RDaddr/RDdata inputs.

Parameters:
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, at least 2)
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may wait before a steal cycle is forced

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- wb_valid_i  in  1  pipeline writeback request this cycle
- wb_addr_i  in  5  writeback destination register
- wb_data_i  in  32  writeback data
- mdu_issue_i  in  1  MDU op issued this cycle; marks destination busy
- mdu_issue_addr_i  in  5  destination of the issued MDU op
- mdu_valid_i  in  1  MDU result valid
- mdu_addr_i  in  5  MDU result destination
- mdu_data_i  in  32  MDU result data
- mdu_ready_o  out  1  FIFO can accept a result (not full)
- rs_addr_i  in  5  decode-stage source register RS
- rt_addr_i  in  5  decode-stage source register RT
- hazard_o  out  1  RS or RT has a pending MDU result
- stall_o  out  1  steal cycle: pipeline must freeze; wb_valid_i is ignored
- RegWrite_o  out  1  register-file write enable (registered)
- RDaddr_o  out  5  register-file write address (registered)
- RDdata_o  out  32  register-file write data (registered)

Behaviour:
- Reset (async, rst_i=1): FIFO empty, all busy bits 0, state IDLE, starve counter 0. Outputs RegWrite_o=0, RDaddr_o=0, RDdata_o=0, stall_o=0, mdu_ready_o=1, hazard_o=0.
- FIFO push when mdu_valid_i && mdu_ready_o. Pointers wrap modulo FIFO_DEPTH. mdu_ready_o = !full, combinational from the occupancy count.
- Simultaneous push and pop on a full FIFO is not allowed. The push is refused because ready=0 that cycle.
- Grant each cycle, first match wins:
  - state STEAL: grant the FIFO head; stall_o=1; wb_valid_i is ignored.
  - wb_valid_i=1: grant WB.
  - FIFO not empty: grant the FIFO head (pop).
  - otherwise: no grant.
- Write output latency is 1 cycle: the grant in cycle t drives RegWrite_o/RDaddr_o/RDdata_o in cycle t+1.
- A granted write to address 0 yields RegWrite_o=0 in t+1 (RDaddr_o/RDdata_o still update). The entry is still popped and its scoreboard clear still happens.
- Cycles with no grant drive RegWrite_o=0 and hold RDaddr_o/RDdata_o.
- FSM:
  - IDLE: FIFO empty; counter 0. -> WAIT on the cycle a push makes the FIFO non-empty.
  - WAIT: counter increments each cycle the head is blocked by wb_valid_i and resets to 0 on any pop.
    - counter reaches STARVE_LIMIT-1 while blocked -> STEAL.
    - FIFO becomes empty -> IDLE.
  - STEAL: exactly one cycle; stall_o=1; head popped. Next state is WAIT if entries remain, else IDLE; counter cleared.
  - stall_o is a Moore output (STEAL only).
- Pipeline contract: during stall_o=1 the pipeline freezes, so the same WB request is re-presented the next cycle.
- Scoreboard:
  - busy[mdu_issue_addr_i] is set on mdu_issue_i when the address is not 0.
  - busy[addr] is cleared when an MDU entry with that addr is granted.
  - Set and clear of the same address in the same cycle: set wins.
  - WB grants never touch busy bits.
  - hazard_o = (busy[rs_addr_i] && rs_addr_i!=0) || (busy[rt_addr_i] && rt_addr_i!=0), combinational.
- Reset mid-operation: buffered results are discarded, busy bits cleared, any in-flight write output is dropped (RegWrite_o=0 immediately).

Decomposition:
- Shared package: REG_ADDR_W=5, REG_DATA_W=32, state encoding (IDLE, WAIT, STEAL), REG_ZERO=5'd0.
- One natural sub-module: mdu_result_fifo, a synchronous FIFO with push/pop/full/empty and asynchronous reset, storing {addr, data}.
- Arbiter FSM and scoreboard stay in the top module.

Test Plan:
- WB only: wb_valid_i=1, addr 5, data 0x1234 at cycle t -> RegWrite_o=1, RDaddr_o=5, RDdata_o=0x1234 at t+1; stall_o=0 throughout.
- MDU only: issue addr 8 -> hazard_o=1 for rs=8. Then result addr 8, data 0xDEAD -> write at t+1, busy[8] cleared, hazard_o=0.
- Starvation: one MDU entry queued with wb_valid_i=1 every cycle and STARVE_LIMIT=4 -> stall_o=1 for exactly one cycle in the 4th blocked cycle; MDU data written next cycle; WB write resumes the cycle after.
- Full FIFO: push 2 results while WB is continuously valid -> mdu_ready_o=0; a third mdu_valid_i is not accepted; ready returns to 1 the cycle after the steal pop.
- Address 0: MDU result to r0 -> RegWrite_o=0, FIFO pops, no hazard ever reported for r0; simultaneous issue and drain of addr 3 -> busy[3] stays 1.
- Reset: assert rst_i with 2 entries queued and state WAIT -> all outputs return to reset values asynchronously; no writes after release until new requests arrive.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_arbiter_pkg
// Brief   : Shared widths, arbiter state encoding and MDU FIFO entry type.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STEAL = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } mdu_entry_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module  : mdu_result_fifo
// Brief   : Small synchronous FIFO buffering MDU results as {addr, data}.
// Revision: 1.0 - initial release
// ============================================================================
module mdu_result_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  mdu_entry_t       wr_entry,
    output mdu_entry_t       rd_entry,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    mdu_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign rd_entry = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_entry;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_arbiter
// Brief   : Shares the register-file write port between WB and buffered MDU
//           results, with a starvation steal cycle and a busy scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [REG_DATA_W-1:0] wb_data_i,
    input  logic                  mdu_issue_i,
    input  logic [REG_ADDR_W-1:0] mdu_issue_addr_i,
    input  logic                  mdu_valid_i,
    input  logic [REG_ADDR_W-1:0] mdu_addr_i,
    input  logic [REG_DATA_W-1:0] mdu_data_i,
    output logic                  mdu_ready_o,
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    output logic                  hazard_o,
    output logic                  stall_o,
    output logic                  RegWrite_o,
    output logic [REG_ADDR_W-1:0] RDaddr_o,
    output logic [REG_DATA_W-1:0] RDdata_o
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int FCNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int SCNT_W   = $clog2(STARVE_LIMIT) + 1;
    localparam logic [SCNT_W-1:0] STEAL_AT = SCNT_W'(STARVE_LIMIT - 1);

    arb_state_t          state, state_next;
    logic [SCNT_W-1:0]   starve_cnt, starve_next;
    logic [NUM_REGS-1:0] busy, busy_next;

    mdu_entry_t          push_entry, head;
    logic                fifo_full, fifo_empty;
    logic [FCNT_W-1:0]   fifo_count;
    logic                push, grant_wb, grant_mdu, blocked, drains;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [REG_DATA_W-1:0] wr_data;

    assign mdu_ready_o     = !fifo_full;
    assign push            = mdu_valid_i && !fifo_full;
    assign push_entry.addr = mdu_addr_i;
    assign push_entry.data = mdu_data_i;

    mdu_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push),
        .pop      (grant_mdu),
        .wr_entry (push_entry),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign stall_o  = (state == ST_STEAL);
    assign blocked  = (state == ST_WAIT) && wb_valid_i && !fifo_empty;
    assign drains   = grant_mdu && !push && (fifo_count == FCNT_W'(1));
    assign hazard_o = (busy[rs_addr_i] && (rs_addr_i != REG_ZERO)) ||
                      (busy[rt_addr_i] && (rt_addr_i != REG_ZERO));

    always_comb begin
        grant_wb  = 1'b0;
        grant_mdu = 1'b0;
        wr_addr   = wb_addr_i;
        wr_data   = wb_data_i;
        if (state == ST_STEAL) begin
            grant_mdu = !fifo_empty;
        end else if (wb_valid_i) begin
            grant_wb = 1'b1;
        end else if (!fifo_empty) begin
            grant_mdu = 1'b1;
        end
        if (grant_mdu) begin
            wr_addr = head.addr;
            wr_data = head.data;
        end
    end

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        case (state)
            ST_IDLE: begin
                starve_next = '0;
                if (push) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (drains) begin
                    state_next  = ST_IDLE;
                    starve_next = '0;
                end else if (grant_mdu) begin
                    starve_next = '0;
                end else if (blocked) begin
                    starve_next = starve_cnt + SCNT_W'(1);
                    if (starve_cnt + SCNT_W'(1) == STEAL_AT) state_next = ST_STEAL;
                end
            end
            ST_STEAL: begin
                starve_next = '0;
                state_next  = drains ? ST_IDLE : ST_WAIT;
            end
            default: begin
                state_next  = ST_IDLE;
                starve_next = '0;
            end
        endcase
    end

    // Issue is applied after the drain clear so a same-cycle set wins.
    always_comb begin
        busy_next = busy;
        if (grant_mdu) busy_next[head.addr] = 1'b0;
        if (mdu_issue_i && (mdu_issue_addr_i != REG_ZERO)) busy_next[mdu_issue_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            busy       <= '0;
            RegWrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            busy       <= busy_next;
            if (grant_wb || grant_mdu) begin
                RegWrite_o <= (wr_addr != REG_ZERO);
                RDaddr_o   <= wr_addr;
                RDdata_o   <= wr_data;
            end else begin
                RegWrite_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_write_arbiter
// Brief   : Directed self-checking bench for regfile_write_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_valid_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        mdu_issue_i;
    logic [4:0]  mdu_issue_addr_i;
    logic        mdu_valid_i;
    logic [4:0]  mdu_addr_i;
    logic [31:0] mdu_data_i;
    logic        mdu_ready_o;
    logic [4:0]  rs_addr_i;
    logic [4:0]  rt_addr_i;
    logic        hazard_o;
    logic        stall_o;
    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    regfile_write_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .wb_valid_i       (wb_valid_i),
        .wb_addr_i        (wb_addr_i),
        .wb_data_i        (wb_data_i),
        .mdu_issue_i      (mdu_issue_i),
        .mdu_issue_addr_i (mdu_issue_addr_i),
        .mdu_valid_i      (mdu_valid_i),
        .mdu_addr_i       (mdu_addr_i),
        .mdu_data_i       (mdu_data_i),
        .mdu_ready_o      (mdu_ready_o),
        .rs_addr_i        (rs_addr_i),
        .rt_addr_i        (rt_addr_i),
        .hazard_o         (hazard_o),
        .stall_o          (stall_o),
        .RegWrite_o       (RegWrite_o),
        .RDaddr_o         (RDaddr_o),
        .RDdata_o         (RDdata_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},     RegWrite_o,  0);
        check({tag, "_addr"},   RDaddr_o,    0);
        check({tag, "_data"},   RDdata_o,    0);
        check({tag, "_stall"},  stall_o,     0);
        check({tag, "_ready"},  mdu_ready_o, 1);
        check({tag, "_hazard"}, hazard_o,    0);
    endtask

    initial begin
        rst_i = 1'b1;
        wb_valid_i = 0; wb_addr_i = 0; wb_data_i = 0;
        mdu_issue_i = 0; mdu_issue_addr_i = 0;
        mdu_valid_i = 0; mdu_addr_i = 0; mdu_data_i = 0;
        rs_addr_i = 0; rt_addr_i = 0;
        #3;
        check_reset_outputs("reset");
        #10;
        rst_i = 1'b0;
        tick();

        // Writeback only
        wb_valid_i = 1; wb_addr_i = 5; wb_data_i = 32'h1234;
        tick();
        check("wb_we",    RegWrite_o, 1);
        check("wb_addr",  RDaddr_o,   5);
        check("wb_data",  RDdata_o,   32'h1234);
        check("wb_stall", stall_o,    0);
        wb_valid_i = 0;
        tick();
        check("idle_we",        RegWrite_o, 0);
        check("idle_addr_hold", RDaddr_o,   5);
        check("idle_data_hold", RDdata_o,   32'h1234);

        // MDU only: issue marks busy, drain clears it
        mdu_issue_i = 1; mdu_issue_addr_i = 8; rs_addr_i = 8;
        tick();
        mdu_issue_i = 0;
        settle();
        check("mdu_hazard_set", hazard_o, 1);
        mdu_valid_i = 1; mdu_addr_i = 8; mdu_data_i = 32'hDEAD;
        tick();
        mdu_valid_i = 0;
        settle();
        check("mdu_hazard_pending", hazard_o, 1);
        check("mdu_push_cycle_we",  RegWrite_o, 0);
        tick();
        check("mdu_we",           RegWrite_o, 1);
        check("mdu_addr",         RDaddr_o,   8);
        check("mdu_data",         RDdata_o,   32'hDEAD);
        check("mdu_hazard_clear", hazard_o,   0);
        rs_addr_i = 0;

        // Starvation: one entry blocked by continuous WB
        wb_valid_i = 1; wb_addr_i = 6; wb_data_i = 32'h1111;
        mdu_valid_i = 1; mdu_addr_i = 9; mdu_data_i = 32'hBEEF;
        tick();
        mdu_valid_i = 0;
        check("starve_wb0_addr", RDaddr_o, 6);
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("starve_stall_%0d", i), stall_o, (i == 3) ? 1 : 0);
            check($sformatf("starve_wbaddr_%0d", i), RDaddr_o, 6);
            tick();
        end
        check("starve_mdu_we",    RegWrite_o, 1);
        check("starve_mdu_addr",  RDaddr_o,   9);
        check("starve_mdu_data",  RDdata_o,   32'hBEEF);
        check("starve_stall_end", stall_o,    0);
        tick();
        check("starve_wb_resume_addr", RDaddr_o, 6);
        check("starve_wb_resume_data", RDdata_o, 32'h1111);

        // Full FIFO under continuous WB
        wb_addr_i = 20; wb_data_i = 32'h2020;
        mdu_valid_i = 1; mdu_addr_i = 10; mdu_data_i = 32'hA;
        tick();
        mdu_addr_i = 11; mdu_data_i = 32'hB;
        tick();
        settle();
        check("full_ready0", mdu_ready_o, 0);
        mdu_addr_i = 12; mdu_data_i = 32'hC;
        tick();
        mdu_valid_i = 0;
        check("full_ready_c4", mdu_ready_o, 0);
        check("full_stall_c4", stall_o,     0);
        tick();
        check("full_stall_c5", stall_o,     1);
        check("full_ready_c5", mdu_ready_o, 0);
        tick();
        check("full_ready_back", mdu_ready_o, 1);
        check("full_stall_c6",   stall_o,     0);
        check("full_pop1_addr",  RDaddr_o,    10);
        check("full_pop1_data",  RDdata_o,    32'hA);
        tick(); tick(); tick();
        check("full_stall_c9", stall_o, 1);
        tick();
        check("full_pop2_addr", RDaddr_o, 11);
        check("full_pop2_data", RDdata_o, 32'hB);
        wb_valid_i = 0;
        tick();
        check("full_refused_we", RegWrite_o, 0);
        tick();
        check("full_refused_we2", RegWrite_o, 0);

        // Address 0 result: suppressed write, still popped, never hazards
        mdu_issue_i = 1; mdu_issue_addr_i = 0;
        mdu_valid_i = 1; mdu_addr_i = 0; mdu_data_i = 32'h55;
        tick();
        mdu_issue_i = 0; mdu_valid_i = 0;
        settle();
        check("r0_hazard", hazard_o, 0);
        tick();
        check("r0_we",   RegWrite_o, 0);
        check("r0_addr", RDaddr_o,   0);
        check("r0_data", RDdata_o,   32'h55);
        mdu_valid_i = 1; mdu_addr_i = 7; mdu_data_i = 32'h77;
        tick();
        mdu_valid_i = 0;
        tick();
        check("r0_popped_we",   RegWrite_o, 1);
        check("r0_popped_addr", RDaddr_o,   7);
        check("r0_popped_data", RDdata_o,   32'h77);

        // Same-cycle issue and drain of r3: set wins
        mdu_issue_i = 1; mdu_issue_addr_i = 3;
        tick();
        mdu_issue_i = 0;
        mdu_valid_i = 1; mdu_addr_i = 3; mdu_data_i = 32'h33;
        tick();
        mdu_valid_i = 0;
        mdu_issue_i = 1; mdu_issue_addr_i = 3;
        tick();
        mdu_issue_i = 0; rt_addr_i = 3;
        settle();
        check("r3_set_wins_hazard", hazard_o,   1);
        check("r3_drain_we",        RegWrite_o, 1);
        check("r3_drain_addr",      RDaddr_o,   3);
        mdu_valid_i = 1; mdu_addr_i = 3; mdu_data_i = 32'h34;
        tick();
        mdu_valid_i = 0;
        tick();
        settle();
        check("r3_hazard_clear", hazard_o, 0);
        check("r3_second_data",  RDdata_o, 32'h34);
        rt_addr_i = 0;

        // Asynchronous reset with two entries queued in WAIT
        mdu_issue_i = 1; mdu_issue_addr_i = 13; rs_addr_i = 13;
        tick();
        mdu_issue_i = 0;
        wb_valid_i = 1; wb_addr_i = 21; wb_data_i = 32'h2121;
        mdu_valid_i = 1; mdu_addr_i = 14; mdu_data_i = 32'hE;
        tick();
        mdu_addr_i = 15; mdu_data_i = 32'hF;
        tick();
        mdu_valid_i = 0;
        settle();
        check("pre_rst_ready",  mdu_ready_o, 0);
        check("pre_rst_we",     RegWrite_o,  1);
        check("pre_rst_hazard", hazard_o,    1);
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        wb_valid_i = 0;
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_we_%0d", i), RegWrite_o, 0);
        end
        check("post_rst_hazard", hazard_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
